// File: rtl/multi_cycle_control.sv
// Purpose: FSM control unit sequencing IF/ID/EXE/MEM/WB and driving every datapath control line.
// Latency: j/jr/jal/nop 2 cycles, branch 3, ALU 4, sw 4, lw 5; control outputs are combinational from state.
// Backpressure: none; the sequencer free-runs every cycle and parks in ID on halt until reset.
module multi_cycle_control #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             Zero,
  input  logic             Sign,
  output logic [2:0]       state,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic             ExtSel,
  output logic             DBSrc,
  output logic             WrRegSrc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110101);
  localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(6'b110110);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

  state_t state_q, state_d;

  // Decoded opcode attributes shared by the EXE/WB states.
  logic       is_alu;
  logic       alu_imm;
  logic       alu_shift;
  logic       alu_zext;
  logic [2:0] alu_op;
  logic       br_taken;

  // Raw (ungated) control lines; the write enables are masked by reset below.
  logic       pc_we, ir_we, reg_we, mem_we, halt_c;

  // Opcode decode: ALU operation, operand sources, extension mode, branch outcome.
  always_comb begin
    is_alu    = 1'b1;
    alu_imm   = 1'b0;
    alu_shift = 1'b0;
    alu_zext  = 1'b0;
    alu_op    = 3'b000;
    br_taken  = 1'b0;
    case (opcode)
      OP_ADD:  alu_op = 3'b000;
      OP_SUB:  alu_op = 3'b001;
      OP_ADDI: begin alu_op = 3'b000; alu_imm = 1'b1; end
      OP_OR:   alu_op = 3'b011;
      OP_AND:  alu_op = 3'b100;
      OP_ORI:  begin alu_op = 3'b011; alu_imm = 1'b1; alu_zext = 1'b1; end
      OP_SLL:  begin alu_op = 3'b010; alu_shift = 1'b1; end
      OP_SLT:  alu_op = 3'b101;
      OP_SLTI: begin alu_op = 3'b101; alu_imm = 1'b1; end
      default: is_alu = 1'b0;
    endcase
    case (opcode)
      OP_BEQ:  br_taken = Zero;
      OP_BNE:  br_taken = ~Zero;
      OP_BLTZ: br_taken = Sign;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and control outputs; every enable defaults off, selects default to zero.
  always_comb begin
    state_d  = state_q;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    halt_c   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 1'b0;
    ALUOp    = 3'b000;
    PCSrc    = 2'b00;
    RegDst   = 2'b00;
    ExtSel   = 1'b1;
    DBSrc    = 1'b0;
    WrRegSrc = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            pc_we = 1'b1; PCSrc = 2'b11; state_d = S_IF;
          end
          OP_JR: begin
            pc_we = 1'b1; PCSrc = 2'b10; state_d = S_IF;
          end
          OP_JAL: begin
            pc_we    = 1'b1; PCSrc = 2'b11;
            reg_we   = 1'b1; RegDst = 2'b00; WrRegSrc = 1'b0;
            state_d  = S_IF;
          end
          OP_HALT: begin
            halt_c  = 1'b1;
            state_d = S_ID;
          end
          OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_EXE_BR;
          OP_SW, OP_LW:            state_d = S_EXE_LS;
          default: begin
            if (is_alu) begin
              state_d = S_EXE_AL;
            end else begin
              // Unknown opcode retires as a nop.
              pc_we = 1'b1; PCSrc = 2'b00; state_d = S_IF;
            end
          end
        endcase
      end
      S_EXE_AL: begin
        ALUOp   = alu_op;
        ALUSrcA = alu_shift;
        ALUSrcB = alu_imm;
        ExtSel  = ~alu_zext;
        state_d = S_WB_AL;
      end
      S_WB_AL: begin
        ALUOp    = alu_op;
        ALUSrcA  = alu_shift;
        ALUSrcB  = alu_imm;
        ExtSel   = ~alu_zext;
        reg_we   = 1'b1;
        DBSrc    = 1'b0;
        WrRegSrc = 1'b1;
        RegDst   = alu_imm ? 2'b01 : 2'b10;
        pc_we    = 1'b1;
        PCSrc    = 2'b00;
        state_d  = S_IF;
      end
      S_EXE_BR: begin
        ALUOp   = 3'b001;
        ALUSrcB = 1'b0;
        ExtSel  = 1'b1;
        pc_we   = 1'b1;
        PCSrc   = br_taken ? 2'b01 : 2'b00;
        state_d = S_IF;
      end
      S_EXE_LS: begin
        ALUOp   = 3'b000;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        // Address stays on the bus through the memory access.
        ALUOp   = 3'b000;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if (opcode == OP_SW) begin
          mem_we  = 1'b1;
          pc_we   = 1'b1;
          PCSrc   = 2'b00;
          state_d = S_IF;
        end else begin
          state_d = S_WB_LD;
        end
      end
      S_WB_LD: begin
        reg_we   = 1'b1;
        RegDst   = 2'b01;
        DBSrc    = 1'b1;
        WrRegSrc = 1'b1;
        pc_we    = 1'b1;
        PCSrc    = 2'b00;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // A reset cycle must not disturb architectural state, even mid-instruction.
  assign PCWrite  = pc_we  & ~reset;
  assign IRWrite  = ir_we  & ~reset;
  assign RegWrite = reg_we & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign halted   = halt_c & ~reset;
  assign state    = state_q;

  // State register with synchronous reset back to instruction fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter: one count per PC update, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
    end else if (PCWrite) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Purpose: randomized scoreboard bench for the multi-cycle control FSM.
// Latency: expected per-instruction state path and retire-cycle controls come from an instruction-class model.
// Backpressure: none; the driver paces instructions by their modelled latency.
module tb_multi_cycle_control;

  localparam int CW = 4;

  localparam logic [2:0] IF = 3'b000, ID = 3'b001, ELS = 3'b010, MEM = 3'b011,
                         WLD = 3'b100, EBR = 3'b101, EAL = 3'b110, WAL = 3'b111;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          Zero, Sign;
  logic [2:0]    state;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB;
  logic [2:0]    ALUOp;
  logic [1:0]    PCSrc, RegDst;
  logic          ExtSel, DBSrc, WrRegSrc, halted;
  logic [CW-1:0] instr_count;

  multi_cycle_control #(.OP_W(6), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero), .Sign(Sign),
    .state(state), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .RegDst(RegDst), .ExtSel(ExtSel), .DBSrc(DBSrc),
    .WrRegSrc(WrRegSrc), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][2:0] seq;     // state visited in each cycle of the instruction
    int              n;       // cycles from IF to retire
    logic            halt;
    logic [1:0]      pcsrc;
    logic            rw, mw;
    logic [1:0]      regdst;
    logic            dbsrc, wrsrc;
    logic            alu;     // ALUOp/ALUSrcB/ExtSel meaningful at retire
    logic            achk;    // ALUSrcA meaningful at retire
    logic [2:0]      aluop;
    logic            srca, srcb, ext;
    int              cnt;     // instr_count while this instruction is in flight
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cnt_model = 0;

  logic [5:0] ops [18] = '{6'o00, 6'o01, 6'o02, 6'o20, 6'o21, 6'o22, 6'o30, 6'o46, 6'o47,
                           6'o60, 6'o61, 6'o64, 6'o65, 6'o66, 6'o70, 6'o71, 6'o72, 6'o77};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Instruction-class model: path through the states and what the retire cycle must show.
  function automatic exp_t model(input logic [5:0] op, input logic z, input logic s, input int cnt);
    exp_t e;
    e = '0;
    e.cnt = cnt;
    e.seq[0] = IF;
    e.seq[1] = ID;
    e.n = 2;
    case (op)
      6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000, 6'b100110,
      6'b000010, 6'b010010, 6'b100111: begin
        e.n = 4; e.seq[2] = EAL; e.seq[3] = WAL;
        e.rw = 1; e.wrsrc = 1; e.dbsrc = 0;
        e.srcb = (op == 6'b000010 || op == 6'b010010 || op == 6'b100111);
        e.regdst = e.srcb ? 2'b01 : 2'b10;
        e.alu = 1; e.achk = 1;
        e.srca = (op == 6'b011000);
        e.ext = (op != 6'b010010);
        case (op)
          6'b000001:           e.aluop = 3'd1;
          6'b011000:           e.aluop = 3'd2;
          6'b010000, 6'b010010: e.aluop = 3'd3;
          6'b010001:           e.aluop = 3'd4;
          6'b100110, 6'b100111: e.aluop = 3'd5;
          default:             e.aluop = 3'd0;
        endcase
      end
      6'b110000: begin
        e.n = 4; e.seq[2] = ELS; e.seq[3] = MEM; e.mw = 1;
        e.alu = 1; e.aluop = 3'd0; e.srcb = 1; e.ext = 1;
      end
      6'b110001: begin
        e.n = 5; e.seq[2] = ELS; e.seq[3] = MEM; e.seq[4] = WLD;
        e.rw = 1; e.regdst = 2'b01; e.dbsrc = 1; e.wrsrc = 1;
      end
      6'b110100, 6'b110101, 6'b110110: begin
        e.n = 3; e.seq[2] = EBR;
        e.alu = 1; e.aluop = 3'd1; e.srcb = 0; e.ext = 1;
        if ((op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s))
          e.pcsrc = 2'b01;
      end
      6'b111000: e.pcsrc = 2'b11;
      6'b111001: e.pcsrc = 2'b10;
      6'b111010: begin e.pcsrc = 2'b11; e.rw = 1; e.regdst = 2'b00; e.wrsrc = 0; end
      6'b111111: e.halt = 1;
      default:   e.pcsrc = 2'b00;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_model = 0;
  endtask

  // Issue one instruction at the start of an IF cycle; abort_at>0 resets during that cycle index.
  task automatic issue(input logic [5:0] op, input logic z, input logic s, input int abort_at);
    exp_t e;
    opcode = op; Zero = z; Sign = s;
    e = model(op, z, s, cnt_model);
    q.push_back(e);
    if (abort_at > 0 && abort_at < e.n) begin
      repeat (abort_at) @(posedge clk);
      #1;
      do_reset();
    end else if (e.halt) begin
      repeat (6) @(posedge clk);
      #1;
      do_reset();
    end else begin
      cnt_model = (cnt_model + 1) % (1 << CW);
      repeat (e.n) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every cycle against the instruction at the head of the scoreboard.
  initial begin : monitor
    int   cyc;
    int   idx;
    logic last;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        chk("reset_halted", halted, 1'b0);
        cyc = 0;
      end else if (q.size() == 0) begin
        chk("scoreboard_underflow", q.size(), 1);
        cyc++;
      end else begin
        e = q[0];
        last = !e.halt && (cyc == e.n - 1);
        idx = (cyc < e.n) ? cyc : e.n - 1;
        chk("state", state, e.seq[idx]);
        chk("irwrite", IRWrite, idx == 0);
        chk("pcwrite", PCWrite, last);
        chk("regwrite", RegWrite, last && e.rw);
        chk("memwrite", MemWrite, last && e.mw);
        chk("halted", halted, e.halt && cyc >= 1);
        chk("instr_count", instr_count, e.cnt);
        if (last) begin
          chk("pcsrc", PCSrc, e.pcsrc);
          if (e.rw) begin
            chk("regdst", RegDst, e.regdst);
            chk("wrregsrc", WrRegSrc, e.wrsrc);
            if (e.wrsrc) chk("dbsrc", DBSrc, e.dbsrc);
          end
          if (e.alu) begin
            chk("aluop", ALUOp, e.aluop);
            chk("alusrcb", ALUSrcB, e.srcb);
            chk("extsel", ExtSel, e.ext);
          end
          if (e.achk) chk("alusrca", ALUSrcA, e.srca);
          void'(q.pop_front());
          cyc = 0;
        end else begin
          cyc++;
        end
      end
    end
  end

  // Driver: directed instruction classes first, then a randomized stream with halts and aborts.
  initial begin : driver
    logic [5:0] op;
    int         r;
    exp_t       e;
    reset = 1'b1; opcode = 6'b0; Zero = 1'b0; Sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(6'b000000, 0, 0, 0);          // add
    chk("count_after_add", instr_count, 1);
    issue(6'b110001, 0, 0, 0);          // lw
    issue(6'b110000, 0, 0, 0);          // sw
    issue(6'b110100, 1, 0, 0);          // beq taken
    issue(6'b110100, 0, 0, 0);          // beq not taken
    issue(6'b110101, 1, 0, 0);          // bne not taken
    issue(6'b110101, 0, 0, 0);          // bne taken
    issue(6'b110110, 0, 1, 0);          // bltz taken
    issue(6'b110110, 1, 0, 0);          // bltz not taken
    issue(6'b111010, 0, 0, 0);          // jal
    issue(6'b111000, 0, 0, 0);          // j
    issue(6'b111001, 0, 0, 0);          // jr
    issue(6'b000011, 0, 0, 0);          // undefined -> nop
    issue(6'b011000, 0, 0, 0);          // sll
    issue(6'b010010, 0, 0, 0);          // ori
    issue(6'b110000, 0, 0, 3);          // reset while sw in MEM
    issue(6'b110001, 0, 0, 3);          // reset while lw in MEM
    issue(6'b110001, 0, 0, 4);          // reset while lw in WB_LD
    issue(6'b111111, 0, 0, 0);          // halt, then reset

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 1) op = ops[$urandom_range(0, 16)];
      else                           op = 6'($urandom_range(0, 63));
      r = int'($urandom_range(0, 24));
      if (r == 0) op = 6'b111111;
      e = model(op, 1'b0, 1'b0, 0);
      issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (r == 1 && e.n > 1) ? int'($urandom_range(1, e.n - 1)) : 0);
    end

    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- FSM control unit for the multi-cycle CPU.
- Sequences every instruction through IF/ID/EXE/MEM/WB and drives all datapath control signals (PC, IR, register file, ALU, data memory, mux selects) from the registered state, the IR opcode and the ALU flags.
- Sits directly upstream of the datapath. Its state and control outputs are the signals the CPU top exports for simulation.

Parameters:
- OP_W, 6, opcode width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OP_W  instruction[31:26] from IR; stable from the ID state onward.
- Zero  in  1  ALU result == 0.
- Sign  in  1  ALU result[31].
- state  out  3  current FSM state.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- ALUSrcA  out  1  0=rs, 1=shamt.
- ALUSrcB  out  1  0=rt, 1=extended immediate.
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed).
- PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- RegDst  out  2  00 $31, 01 rt, 10 rd.
- ExtSel  out  1  0 zero-extend, 1 sign-extend.
- DBSrc  out  1  0 ALU result, 1 memory data.
- WrRegSrc  out  1  0 PC+4, 1 DB bus.
- halted  out  1  halt instruction reached.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- State encoding:
  - IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
- Opcodes:
  - R-type / ALU: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, slti 100111.
  - Memory: sw 110000, lw 110001.
  - Branch: beq 110100, bne 110101, bltz 110110.
  - Jump: j 111000, jr 111001, jal 111010.
  - Control: halt 111111.
- Reset (sync, highest priority): state=IF, instr_count=0, halted=0. All write enables are 0 in the reset cycle. A reset in any state, including mid-instruction or halted, returns to IF on the next edge.
- Control outputs are combinational from (state, opcode, Zero, Sign). Every enable not listed for a state is 0. Mux selects are don't-care unless stated.
- IF: IRWrite=1. Next state is ID.
- ID, by opcode:
  - j: PCWrite=1, PCSrc=11; next IF.
  - jr: PCWrite=1, PCSrc=10; next IF.
  - jal: PCWrite=1, PCSrc=11, RegWrite=1, RegDst=00, WrRegSrc=0; next IF.
  - halt: all enables 0, halted=1; stay in ID until reset.
  - beq, bne, bltz: next EXE_BR.
  - sw, lw: next EXE_LS.
  - Listed ALU opcodes: next EXE_AL.
  - Undefined opcode: nop, i.e. PCWrite=1, PCSrc=00; next IF.
- EXE_AL: ALUOp per opcode (addi uses add, ori uses or, slti uses slt). ALUSrcB=1 for addi/ori/slti. ALUSrcA=1 for sll. ExtSel=0 for ori, else 1. Next WB_AL.
- WB_AL: RegWrite=1, DBSrc=0, WrRegSrc=1, RegDst=10 for R-type / 01 for addi/ori/slti, PCWrite=1, PCSrc=00. ALU controls held as in EXE_AL. Next IF.
- EXE_BR: ALUOp=001, ALUSrcB=0, ExtSel=1, PCWrite=1. Taken conditions: beq Zero=1; bne Zero=0; bltz Sign=1. PCSrc=01 if taken, else 00. Next IF.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1. Next MEM.
- MEM: address controls held.
  - sw: MemWrite=1, PCWrite=1, PCSrc=00; next IF.
  - lw: next WB_LD.
- WB_LD: RegWrite=1, RegDst=01, DBSrc=1, WrRegSrc=1, PCWrite=1, PCSrc=00. Next IF.
- Latency in cycles: j/jr/jal/nop 2, branch 3, ALU 4, sw 4, lw 5.
- instr_count increments by 1 on every edge where PCWrite=1 and reset=0. It wraps from all-ones to 0 and does not count halt.
- PCWrite is asserted exactly once per retired instruction, always in the final state before IF.

Test Plan:
- Reset held 2 cycles then released; opcode=add -> state sequence 000,001,110,111,000. RegWrite=1 and PCWrite=1 only in 111. instr_count=1 after 4 cycles.
- opcode=lw -> states 000,001,010,011,100. In 100: RegWrite=1, DBSrc=1, RegDst=01. MemWrite never 1.
- opcode=sw -> MemWrite=1 only in state 011, with PCWrite=1 there. Next state 000.
- opcode=beq with Zero=1 -> PCSrc=01; with Zero=0 -> PCSrc=00. bne inverts. bltz with Sign=1 -> PCSrc=01. Each completes in 3 cycles.
- opcode=jal -> 2-cycle instruction. In ID: RegWrite=1, RegDst=00, WrRegSrc=0, PCSrc=11. opcode=111111 -> halted=1, state stuck at 001, instr_count frozen.
- Reset asserted while in MEM (lw), then while halted -> next edge state=000, instr_count=0, halted=0, no RegWrite/MemWrite pulse during reset.
